fpu_issue_queue: RTL
====================

Name: fpu_issue_queue

Overview:
- Upstream issue stage for the fpu core. Accepts tagged operation requests over a valid/ready handshake and buffers them in a request FIFO.
- Drives the fpu inputs (fpu_op, rmode, opa, opb) one operation per cycle and tracks each in-flight operation through the fixed fpu pipeline latency.
- Captures each fpu result plus its flags into a result FIFO, returned over a valid/ready handshake with the original tag.
- Credit-based issue guarantees the result FIFO never overflows.

Parameters:
BIT_SIZE, 31, operand MSB index (data width = BIT_SIZE+1)
FPU_LATENCY, 4, cycles from fpu input edge to valid fpu out/flags (>=1)
DEPTH, 4, entries in each of the request FIFO and the result FIFO (power of two, >=2)
TAG_W, 4, request tag width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request FIFO not full
req_op  in  3  fpu operation (0 add, 1 sub, 2 mul, 3 div)
req_rmode  in  2  rounding mode (0 = nearest even)
req_opa  in  BIT_SIZE+1  operand A
req_opb  in  BIT_SIZE+1  operand B
req_tag  in  TAG_W  request tag
fpu_op  out  3  registered to fpu
fpu_rmode  out  2  registered to fpu
fpu_opa  out  BIT_SIZE+1  registered to fpu
fpu_opb  out  BIT_SIZE+1  registered to fpu
fpu_out  in  BIT_SIZE+1  fpu result
fpu_flags  in  8  {snan,qnan,inf,ine,overflow,underflow,div_by_zero,zero}
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer accepts result
res_data  out  BIT_SIZE+1  result at FIFO head
res_flags  out  8  flags at FIFO head
res_tag  out  TAG_W  tag at FIFO head
busy  out  1  any request queued, in flight, or unread

Behaviour:
- Reset (sync, rst=1 at edge):
  - Both FIFOs emptied; in-flight shift register cleared.
  - Outputs: req_ready=1, res_valid=0, busy=0; fpu_op/fpu_rmode/fpu_opa/fpu_opb=0; res_data/res_flags/res_tag=0.
  - rst mid-operation discards all queued and in-flight work. fpu results returning afterwards are ignored because their shift-register valid bits are cleared.
- Request accept: edge where req_valid && req_ready. Entry written to the request FIFO.
  - req_ready = (req count < DEPTH). It is combinational on state only, never on req_valid.
  - Full: req_ready=0; req_valid is held by the producer with no loss.
- Issue condition: request FIFO non-empty && (inflight + res_count) < DEPTH. inflight counts set bits in the shift register.
  - On issue edge: fpu_* registers load the head entry; the head pops; shift[0] <= {1, tag}.
  - On non-issue edge: shift[0] <= 0 and fpu_* hold their previous value.
- Shift register: FPU_LATENCY stages of {valid, tag}, advancing every cycle.
  - At the edge where stage FPU_LATENCY-1 is valid, fpu_out/fpu_flags are sampled and written with that tag into the result FIFO.
- Latency: accept at edge N, issue at edge N+1, result captured at edge N+1+FPU_LATENCY. res_valid is high after that edge (minimum FPU_LATENCY+1 cycles, FIFOs empty).
- Throughput: 1 op/cycle sustained while res_ready=1.
- Pop: edge with res_valid && res_ready. res_* are FIFO head values (show-ahead).
- Simultaneous events:
  - Accept+issue in the same cycle: allowed. Request count unchanged.
  - Capture+pop in the same cycle: allowed. Result count unchanged.
  - An accept into an empty request FIFO issues no earlier than the next edge (no bypass).
  - The credit check uses the pre-edge inflight and res_count. A pop in the same cycle does not free a credit until the next cycle.
- Pointers: log2(DEPTH)-bit pointers with wrap, plus a separate count per FIFO. Full is count==DEPTH; empty is count==0.
- busy = req count!=0 || inflight!=0 || res count!=0.

Test Plan:
- Reset then single add: req op=0, opa=3f800000, opb=40000000, tag=5 -> fpu inputs loaded the next edge; res_valid rises 5 cycles after accept with res_data=40400000, res_tag=5, res_flags=0.
- Back-to-back: 4 reqs on consecutive cycles (mul 40000000*40400000, tags 0..3), res_ready=1 -> 4 results on consecutive cycles, first =40c00000, tags in order 0,1,2,3.
- Backpressure: res_ready=0, push 10 reqs -> exactly DEPTH results held, at most DEPTH more queued, req_ready=0. Release res_ready -> all 10 results delivered in order, none lost or duplicated.
- Div by zero: op=3, opa=3f800000, opb=00000000 -> res_data=7f800000 with div_by_zero and inf flags set.
- Reset mid-flight: assert rst for 1 cycle two cycles after issuing 3 ops -> res_valid never rises for them, busy=0 and req_ready=1 after reset.
- Simultaneous: full result FIFO with res_ready=1 and a pending request -> issue occurs one cycle after the pop; order preserved.

Source files
------------

// File: rtl/fpu_issue_queue.sv
// Issue queue in front of a fixed-latency fpu: request FIFO, tagged in-flight
// shift register and result FIFO, with credit-based issue so results always fit.
module fpu_issue_queue #(
  parameter int BIT_SIZE    = 31,
  parameter int FPU_LATENCY = 4,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [1:0]          req_rmode,
  input  logic [BIT_SIZE:0]   req_opa,
  input  logic [BIT_SIZE:0]   req_opb,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [2:0]          fpu_op,
  output logic [1:0]          fpu_rmode,
  output logic [BIT_SIZE:0]   fpu_opa,
  output logic [BIT_SIZE:0]   fpu_opb,
  input  logic [BIT_SIZE:0]   fpu_out,
  input  logic [7:0]          fpu_flags,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BIT_SIZE:0]   res_data,
  output logic [7:0]          res_flags,
  output logic [TAG_W-1:0]    res_tag,
  output logic                busy
);
  localparam int DW = BIT_SIZE + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       rmode;
    logic [DW-1:0]    opa;
    logic [DW-1:0]    opb;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [7:0]       flags;
    logic [TAG_W-1:0] tag;
  } res_t;

  req_t             req_mem [DEPTH];
  logic [PW-1:0]    req_wr_ptr_reg, req_rd_ptr_reg;
  logic [CW-1:0]    req_count_reg;
  res_t             res_mem [DEPTH];
  logic [PW-1:0]    res_wr_ptr_reg, res_rd_ptr_reg;
  logic [CW-1:0]    res_count_reg;
  logic [FPU_LATENCY-1:0] stage_valid_reg;
  logic [TAG_W-1:0] stage_tag_reg [FPU_LATENCY];

  logic       req_accept, issue, capture, res_pop;
  logic [CW:0] inflight, credit_used;
  req_t       req_head;
  res_t       res_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < FPU_LATENCY; i++)
      inflight = inflight + (CW + 1)'(stage_valid_reg[i]);
  end

  // Every in-flight op already owns a result slot, so issue only when one is still free.
  assign credit_used = inflight + {1'b0, res_count_reg};
  assign req_ready   = (req_count_reg != FULL_C);
  assign req_accept  = req_valid && req_ready;
  assign issue       = (req_count_reg != '0) && (credit_used < CREDITS);
  assign capture     = stage_valid_reg[FPU_LATENCY-1];
  assign res_valid   = (res_count_reg != '0);
  assign res_pop     = res_valid && res_ready;
  assign req_head    = req_mem[req_rd_ptr_reg];
  assign res_head    = res_mem[res_rd_ptr_reg];
  assign busy        = (req_count_reg != '0) || (inflight != '0) || res_valid;

  // Head is masked while empty so the result outputs read zero after reset.
  assign res_data  = res_valid ? res_head.data  : '0;
  assign res_flags = res_valid ? res_head.flags : '0;
  assign res_tag   = res_valid ? res_head.tag   : '0;

  always_ff @(posedge clk) begin
    if (req_accept)
      req_mem[req_wr_ptr_reg] <= '{op: req_op, rmode: req_rmode, opa: req_opa,
                                   opb: req_opb, tag: req_tag};
    if (capture)
      res_mem[res_wr_ptr_reg] <= '{data: fpu_out, flags: fpu_flags,
                                   tag: stage_tag_reg[FPU_LATENCY-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_ptr_reg <= '0;
      req_rd_ptr_reg <= '0;
      req_count_reg  <= '0;
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_count_reg  <= '0;
    end else begin
      if (req_accept) req_wr_ptr_reg <= req_wr_ptr_reg + PW'(1);
      if (issue)      req_rd_ptr_reg <= req_rd_ptr_reg + PW'(1);
      if (req_accept && !issue)      req_count_reg <= req_count_reg + CW'(1);
      else if (!req_accept && issue) req_count_reg <= req_count_reg - CW'(1);

      if (capture) res_wr_ptr_reg <= res_wr_ptr_reg + PW'(1);
      if (res_pop) res_rd_ptr_reg <= res_rd_ptr_reg + PW'(1);
      if (capture && !res_pop)      res_count_reg <= res_count_reg + CW'(1);
      else if (!capture && res_pop) res_count_reg <= res_count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_op    <= '0;
      fpu_rmode <= '0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
    end else if (issue) begin
      fpu_op    <= req_head.op;
      fpu_rmode <= req_head.rmode;
      fpu_opa   <= req_head.opa;
      fpu_opb   <= req_head.opb;
    end
  end

  // Tags travel alongside the op; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) stage_valid_reg <= '0;
    else     stage_valid_reg <= {stage_valid_reg[FPU_LATENCY-2:0], issue};
  end

  always_ff @(posedge clk) begin
    stage_tag_reg[0] <= req_head.tag;
    for (int i = 1; i < FPU_LATENCY; i++)
      stage_tag_reg[i] <= stage_tag_reg[i-1];
  end
endmodule
